// File: rtl/pov_pkg.sv
// Shared mode encodings, default sizing and helpers for the POV angle sequencer.
package pov_pkg;

  localparam int unsigned DEFAULT_STEPS       = 360;
  localparam int unsigned DEFAULT_NUM_LEDS    = 16;
  localparam int unsigned DEFAULT_SYNC_MARGIN = 8;

  typedef enum logic [1:0] {
    MODE_MARKER  = 2'd0,
    MODE_SECTOR  = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  // Smallest width able to hold 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pov_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin followed by a one-cycle rising-edge pulse.
module pov_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic pulse_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], pin_i};
    end
  end

  // A level held high produces a single pulse.
  assign pulse_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pov_angle_sequencer.sv
// Fan blade angle tracker with index resync and a two-stage LED pipeline
// selecting marker, sector, pattern-RAM or off drive.
module pov_angle_sequencer
  import pov_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = DEFAULT_NUM_LEDS,
  parameter int unsigned STEPS       = DEFAULT_STEPS,
  parameter int unsigned SYNC_MARGIN = DEFAULT_SYNC_MARGIN,
  localparam int unsigned AW         = (clog2(STEPS) > 0) ? clog2(STEPS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fanclk,
  input  logic                index,
  input  logic [1:0]          mode,
  input  logic [AW-1:0]       sec_start,
  input  logic [AW-1:0]       sec_end,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [NUM_LEDS-1:0] wr_data,
  output logic [NUM_LEDS-1:0] led,
  output logic [AW-1:0]       angle,
  output logic                synced,
  output logic [15:0]         rev_count
);

  localparam int unsigned   SSI_MAX    = STEPS + SYNC_MARGIN;
  localparam int unsigned   SW         = clog2(SSI_MAX + 1);
  localparam logic [AW-1:0] LAST_ANGLE = AW'(STEPS - 1);
  localparam logic [SW-1:0] SSI_LIMIT  = SW'(SSI_MAX);

  logic step_c;
  logic index_c;

  pov_edge_sync u_fan_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (fanclk),
    .pulse_c (step_c)
  );

  pov_edge_sync u_index_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (index),
    .pulse_c (index_c)
  );

  logic [AW-1:0] angle_q,  angle_d;
  logic          synced_q, synced_d;
  logic [SW-1:0] ssi_q,    ssi_d;
  logic [15:0]   rev_q,    rev_d;

  // Index wins over a coincident step; locked revolutions are counted by index only.
  always_comb begin
    angle_d  = angle_q;
    synced_d = synced_q;
    ssi_d    = ssi_q;
    rev_d    = rev_q;
    if (index_c) begin
      angle_d  = '0;
      synced_d = 1'b1;
      ssi_d    = '0;
      rev_d    = rev_q + 16'd1;
    end else if (step_c) begin
      if (angle_q == LAST_ANGLE) begin
        angle_d = '0;
        if (!synced_q) rev_d = rev_q + 16'd1;
      end else begin
        angle_d = angle_q + AW'(1);
      end
      if (synced_q) begin
        if (ssi_q >= SSI_LIMIT - SW'(1)) begin
          ssi_d    = SSI_LIMIT;
          synced_d = 1'b0;
        end else begin
          ssi_d = ssi_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      angle_q  <= '0;
      synced_q <= 1'b0;
      ssi_q    <= '0;
      rev_q    <= '0;
    end else begin
      angle_q  <= angle_d;
      synced_q <= synced_d;
      ssi_q    <= ssi_d;
      rev_q    <= rev_d;
    end
  end

  logic [NUM_LEDS-1:0] mem [STEPS];

  // Writes beyond the last angle are dropped; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < STEPS)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic in_sector_c;

  always_comb begin
    in_sector_c = 1'b0;
    if (sec_start < sec_end) begin
      in_sector_c = (angle_q >= sec_start) && (angle_q < sec_end);
    end else if (sec_start > sec_end) begin
      in_sector_c = (angle_q >= sec_start) || (angle_q < sec_end);
    end
  end

  logic [NUM_LEDS-1:0] rd_q;
  logic                marker_q;
  logic                sector_q;
  mode_e               mode_q;
  logic [NUM_LEDS-1:0] led_q, led_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q     <= '0;
      marker_q <= 1'b0;
      sector_q <= 1'b0;
      mode_q   <= MODE_MARKER;
    end else begin
      rd_q     <= mem[angle_q];
      marker_q <= (angle_q == '0);
      sector_q <= in_sector_c;
      mode_q   <= mode_e'(mode);
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_MARKER:  led_d = {NUM_LEDS{marker_q}};
      MODE_SECTOR:  led_d = {NUM_LEDS{sector_q}};
      MODE_PATTERN: led_d = rd_q;
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led       = led_q;
  assign angle     = angle_q;
  assign synced    = synced_q;
  assign rev_count = rev_q;

endmodule

// File: tb/tb_pov_angle_sequencer.sv
// Scoreboard bench: each pin pulse queues the state it must produce; a monitor
// pops on every angle/sync/count change and checks LED drive before and after it.
module tb_pov_angle_sequencer;
  import pov_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned NL = 16;
  localparam int          FF = 32'h0000FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          fanclk;
  logic          index;
  logic [1:0]    mode;
  logic [AW-1:0] sec_start;
  logic [AW-1:0] sec_end;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NL-1:0] wr_data;
  logic [NL-1:0] led;
  logic [AW-1:0] angle;
  logic          synced;
  logic [15:0]   rev_count;

  pov_angle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .fanclk    (fanclk),
    .index     (index),
    .mode      (mode),
    .sec_start (sec_start),
    .sec_end   (sec_end),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .led       (led),
    .angle     (angle),
    .synced    (synced),
    .rev_count (rev_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int angle;
    int synced;
    int rev;
    int led_pre;
    int led_post;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  function automatic int mark_led(input int a);
    return (a == 0) ? FF : 0;
  endfunction

  // Sector 350..9 wrapping through zero.
  function automatic int sec_led(input int a);
    return (a >= 350 || a < 10) ? FF : 0;
  endfunction

  task automatic pulse(input bit f, input bit x, input int a, input int s,
                       input int r, input int pre, input int post);
    exp_t e;
    @(negedge clk);
    fanclk = f;
    index  = x;
    e.angle    = a;
    e.synced   = s;
    e.rev      = r;
    e.led_pre  = pre;
    e.led_post = post;
    e.cyc      = cyc + 3;
    exp_q.push_back(e);
    repeat (4) @(negedge clk);
    fanclk = 1'b0;
    index  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = NL'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    logic [AW-1:0] p_angle;
    logic          p_synced;
    logic [15:0]   p_rev;
    int            pre_cyc, post_cyc, pre_val, post_val;
    bit            pre_en, post_en;
    exp_t          e;
    p_angle  = '0;
    p_synced = 1'b0;
    p_rev    = '0;
    pre_cyc  = 0;
    post_cyc = 0;
    pre_val  = 0;
    post_val = 0;
    pre_en   = 1'b0;
    post_en  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        p_angle  = angle;
        p_synced = synced;
        p_rev    = rev_count;
        pre_en   = 1'b0;
        post_en  = 1'b0;
      end else begin
        if (pre_en && cyc == pre_cyc) begin
          check("led_before_update", int'(led), pre_val);
          pre_en = 1'b0;
        end
        if (post_en && cyc == post_cyc) begin
          check("led_two_cycles_after", int'(led), post_val);
          post_en = 1'b0;
        end
        if (angle != p_angle || synced != p_synced || rev_count != p_rev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event at cycle %0d: angle %0d synced %0d rev %0d",
                     cyc, angle, synced, rev_count);
          end else begin
            e = exp_q.pop_front();
            check("angle", int'(angle), e.angle);
            check("synced", int'(synced), e.synced);
            check("rev_count", int'(rev_count), e.rev);
            check("update_cycle", cyc, e.cyc);
            pre_en   = 1'b1;
            pre_cyc  = cyc + 1;
            pre_val  = e.led_pre;
            post_en  = 1'b1;
            post_cyc = cyc + 2;
            post_val = e.led_post;
          end
          p_angle  = angle;
          p_synced = synced;
          p_rev    = rev_count;
        end
      end
    end
  end

  initial begin : stimulus
    int pat [9];
    int t;
    pat = '{32'h0001, 32'h0002, 32'h0003, 32'hA5A5, 32'h0F0F,
            32'h0006, 32'h0007, 32'h0008, 32'h0809};
    rst       = 1'b0;
    fanclk    = 1'b0;
    index     = 1'b0;
    mode      = MODE_MARKER;
    sec_start = '0;
    sec_end   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    // Reset with pins toggling.
    repeat (2) begin
      @(negedge clk);
      fanclk = ~fanclk;
      index  = ~index;
    end
    @(negedge clk);
    fanclk = 1'b0;
    index  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("reset_led", int'(led), 0);
    check("reset_angle", int'(angle), 0);
    check("reset_synced", int'(synced), 0);
    check("reset_rev_count", int'(rev_count), 0);

    // RAM content survives a second reset.
    wr(0, 32'h1234);
    @(negedge clk);
    rst  = 1'b0;
    mode = MODE_PATTERN;
    repeat (2) begin
      @(negedge clk);
      fanclk = ~fanclk;
      index  = ~index;
    end
    @(negedge clk);
    fanclk = 1'b0;
    index  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("ram_kept_over_reset", int'(led), 32'h1234);
    check("reset2_angle", int'(angle), 0);

    // Marker, free-running full revolution.
    @(negedge clk);
    mode = MODE_MARKER;
    settle();
    for (int k = 1; k <= 360; k++)
      pulse(1'b1, 1'b0, k % 360, 0, (k == 360) ? 1 : 0, mark_led(k - 1), mark_led(k % 360));

    // Index after 100 steps, then a coincident step and index, then a plain index.
    for (int k = 1; k <= 100; k++)
      pulse(1'b1, 1'b0, k, 0, 1, mark_led(k - 1), mark_led(k));
    pulse(1'b0, 1'b1, 0, 1, 2, 0, FF);
    for (int k = 1; k <= 5; k++)
      pulse(1'b1, 1'b0, k, 1, 2, mark_led(k - 1), mark_led(k));
    pulse(1'b1, 1'b1, 0, 1, 3, 0, FF);
    for (int k = 1; k <= 3; k++)
      pulse(1'b1, 1'b0, k, 1, 3, mark_led(k - 1), mark_led(k));
    pulse(1'b0, 1'b1, 0, 1, 4, 0, FF);

    // Wrapping sector across a locked wrap, sync loss at step 368, then a free wrap.
    @(negedge clk);
    mode      = MODE_SECTOR;
    sec_start = AW'(350);
    sec_end   = AW'(10);
    settle();
    for (int k = 1; k <= 723; k++)
      pulse(1'b1, 1'b0, k % 360, (k < 368) ? 1 : 0, (k >= 720) ? 5 : 4,
            sec_led((k - 1) % 360), sec_led(k % 360));

    // Empty sector.
    @(negedge clk);
    sec_start = AW'(5);
    sec_end   = AW'(5);
    settle();
    for (int k = 724; k <= 728; k++)
      pulse(1'b1, 1'b0, k % 360, 0, 5, 0, 0);

    // Pattern RAM, including ignored out-of-range writes.
    for (int i = 0; i < 9; i++) wr(i, pat[i]);
    wr(400, 32'hFFFF);
    wr(360, 32'hFFFF);
    @(negedge clk);
    mode = MODE_PATTERN;
    settle();
    pulse(1'b0, 1'b1, 0, 1, 6, pat[8], pat[0]);
    for (int k = 1; k <= 5; k++)
      pulse(1'b1, 1'b0, k, 1, 6, pat[k - 1], pat[k]);

    // Off.
    @(negedge clk);
    mode = MODE_OFF;
    settle();
    pulse(1'b1, 1'b0, 6, 1, 6, 0, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected updates never seen, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
